// File: rtl/control_multi_if.sv
// control_multi_if: bundle between the multicycle MIPS control unit and its
// datapath. The control unit (master) receives the IR opcode and drives every
// mux select and write strobe. It also drives its debug state and the count of
// retired instructions.
interface control_multi_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [5:0]             opcode;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   PCWriteCondNE;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic [1:0]             PCSource;
  logic [3:0]             state;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, instr_count
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, instr_count
  );
endinterface

// File: rtl/control_multi.sv
// control_multi: Moore FSM controller for the multicycle MIPS datapath.
// There is one shared memory and the IR/MDR/A/B/ALUOut registers. Every
// instruction passes through 3 to 5 states. All datapath controls are decoded
// from the current state only. While reset is high, the write/read strobes are
// forced low, so an aborted instruction has no side effects.
// Optional feature macro: ADDI_EN. When it is defined, the controller supports
// addi through the states ADDI_EX and ADDI_WB. When it is not defined, opcode
// 0x08 is treated as illegal.
module control_multi #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  control_multi_if.master bus
);

  // State encodings. The debug output exposes these values, so they are fixed.
  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_BEQ_EX   = 4'd8;
  localparam logic [3:0] S_BNE_EX   = 4'd9;
  localparam logic [3:0] S_JUMP_EX  = 4'd10;
`ifdef ADDI_EN
  localparam logic [3:0] S_ADDI_EX  = 4'd11;
  localparam logic [3:0] S_ADDI_WB  = 4'd12;
`endif

  // Opcodes taken from IR[31:26]
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'h08;
`endif
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic [3:0]             state_q;
  logic [3:0]             state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   terminal_s;

  // Decoded controls before the strobes are gated by reset
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       pc_write_cond_ne_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_source_s;

  // Next-state logic. The opcode matters only in ID and MEMADR.
  // Unused encodings return to IF.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        state_d = S_ID;
      end
      S_ID: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_BNE:       state_d = S_BNE_EX;
          OP_J:         state_d = S_JUMP_EX;
`ifdef ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_IF;  // illegal opcode: refetch, not counted
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else if (bus.opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
`ifdef ADDI_EN
      S_ADDI_EX:  state_d = S_ADDI_WB;
`endif
      default:    state_d = S_IF;  // terminal states and unreachable codes
    endcase
  end

  // Flag for the last state of a legal instruction. The counter advances on
  // the edge that leaves this state.
  always_comb begin
    terminal_s = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ_EX, S_BNE_EX, S_JUMP_EX: terminal_s = 1'b1;
`ifdef ADDI_EN
      S_ADDI_WB: terminal_s = 1'b1;
`endif
      default:   terminal_s = 1'b0;
    endcase
  end

  // Retired-instruction counter. It wraps naturally at 2^COUNT_WIDTH.
  always_comb begin
    if (terminal_s) begin
      count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State and counter registers. Reset takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Moore decode of the datapath controls. Selects that a state does not use
  // are left at zero.
  always_comb begin
    pc_write_s         = 1'b0;
    pc_write_cond_s    = 1'b0;
    pc_write_cond_ne_s = 1'b0;
    iord_s             = 1'b0;
    mem_read_s         = 1'b0;
    mem_write_s        = 1'b0;
    ir_write_s         = 1'b0;
    mem_to_reg_s       = 1'b0;
    reg_dst_s          = 1'b0;
    reg_write_s        = 1'b0;
    alu_src_a_s        = 1'b0;
    alu_src_b_s        = 2'b00;
    alu_op_s           = 2'b00;
    pc_source_s        = 2'b00;
    case (state_q)
      S_IF: begin
        // Fetch the instruction and compute PC+4 in the same cycle
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
        pc_write_s  = 1'b1;
      end
      S_ID: begin
        // Compute the branch target into ALUOut in case this is a branch
        alu_src_b_s = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      S_RTYPE_WB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
      end
      S_BNE_EX: begin
        alu_src_a_s        = 1'b1;
        alu_op_s           = 2'b01;
        pc_write_cond_ne_s = 1'b1;
        pc_source_s        = 2'b01;
      end
      S_JUMP_EX: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
      end
`ifdef ADDI_EN
      S_ADDI_EX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write_s = 1'b1;
      end
`endif
      default: begin
        pc_write_s = 1'b0;  // unreachable codes are inert for their one cycle
      end
    endcase
  end

  // Reset gates every state-changing strobe immediately, so a state
  // interrupted by reset has no effect on the datapath.
  assign bus.PCWrite       = pc_write_s         & ~reset;
  assign bus.PCWriteCond   = pc_write_cond_s    & ~reset;
  assign bus.PCWriteCondNE = pc_write_cond_ne_s & ~reset;
  assign bus.MemRead       = mem_read_s         & ~reset;
  assign bus.MemWrite      = mem_write_s        & ~reset;
  assign bus.IRWrite       = ir_write_s         & ~reset;
  assign bus.RegWrite      = reg_write_s        & ~reset;

  assign bus.IorD        = iord_s;
  assign bus.MemtoReg    = mem_to_reg_s;
  assign bus.RegDst      = reg_dst_s;
  assign bus.ALUSrcA     = alu_src_a_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.PCSource    = pc_source_s;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: testbench for control_multi, driven from a table of vectors.
// Each vector gives the inputs for one cycle and the state/count expected in
// that cycle. The control word is derived from a per-state table, with reset
// masking applied. A second instance with COUNT_WIDTH=4 covers counter
// wraparound and reset priority over the increment.
module tb_control_multi;

  logic clk = 1'b0;
  logic reset1 = 1'b1;
  logic reset2 = 1'b1;

  always #5 clk = ~clk;

  control_multi_if #(.COUNT_WIDTH(32)) bus1 ();
  control_multi_if #(.COUNT_WIDTH(4))  bus2 ();

  control_multi #(.COUNT_WIDTH(32)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  control_multi #(.COUNT_WIDTH(4))  dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  // Control word bit order:
  // {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
  //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]}
  logic [16:0] ctrl1;
  assign ctrl1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.PCWriteCondNE, bus1.IorD,
                  bus1.MemRead, bus1.MemWrite, bus1.IRWrite, bus1.MemtoReg,
                  bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA, bus1.ALUSrcB,
                  bus1.ALUOp, bus1.PCSource};

  // Strobes that reset forces low
  localparam logic [16:0] RST_STROBES = 17'b1_1101_1100_1000_0000;

`ifdef ADDI_EN
  localparam int C_ADDI = 1;
`else
  localparam int C_ADDI = 0;
`endif

  typedef struct {
    logic       rst;
    logic [5:0] opc;
    logic [3:0] exp_state;
    int         exp_count;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [16:0] ctrl_tab[16];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [5:0] opc, input logic [3:0] st, input int cnt);
    vec_t v;
    v.rst = rst; v.opc = opc; v.exp_state = st; v.exp_count = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    vec_t        e;
    logic [16:0] exp_ctrl;
    int          cb;

    for (int s = 0; s < 16; s++) ctrl_tab[s] = 17'd0;
    //                   PCW   PCWC  PCWNE IorD  MR    MW    IRW   M2R   RD    RW    ASA   ASB    AOP    PCS
    ctrl_tab[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
    ctrl_tab[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
    ctrl_tab[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
    ctrl_tab[3]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    ctrl_tab[4]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    ctrl_tab[5]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    ctrl_tab[6]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
    ctrl_tab[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    ctrl_tab[8]  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    ctrl_tab[9]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    ctrl_tab[10] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
    ctrl_tab[11] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
    ctrl_tab[12] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};

    // lw after reset held for two cycles
    add(1'b1, 6'h23, 4'd0, 0);
    add(1'b0, 6'h23, 4'd0, 0);
    add(1'b0, 6'h23, 4'd1, 0);
    add(1'b0, 6'h23, 4'd2, 0);
    add(1'b0, 6'h23, 4'd3, 0);
    add(1'b0, 6'h23, 4'd4, 0);
    // sw, then R-type
    add(1'b0, 6'h2B, 4'd0, 1);
    add(1'b0, 6'h2B, 4'd1, 1);
    add(1'b0, 6'h2B, 4'd2, 1);
    add(1'b0, 6'h2B, 4'd5, 1);
    add(1'b0, 6'h00, 4'd0, 2);
    add(1'b0, 6'h00, 4'd1, 2);
    add(1'b0, 6'h00, 4'd6, 2);
    add(1'b0, 6'h00, 4'd7, 2);
    // beq, bne, j back to back
    add(1'b0, 6'h04, 4'd0, 3);
    add(1'b0, 6'h04, 4'd1, 3);
    add(1'b0, 6'h04, 4'd8, 3);
    add(1'b0, 6'h05, 4'd0, 4);
    add(1'b0, 6'h05, 4'd1, 4);
    add(1'b0, 6'h05, 4'd9, 4);
    add(1'b0, 6'h02, 4'd0, 5);
    add(1'b0, 6'h02, 4'd1, 5);
    add(1'b0, 6'h02, 4'd10, 5);
    // illegal 0x3F, then addi
    add(1'b0, 6'h3F, 4'd0, 6);
    add(1'b0, 6'h3F, 4'd1, 6);
    add(1'b0, 6'h08, 4'd0, 6);
    add(1'b0, 6'h08, 4'd1, 6);
`ifdef ADDI_EN
    add(1'b0, 6'h08, 4'd11, 6);
    add(1'b0, 6'h08, 4'd12, 6);
`endif
    cb = 6 + C_ADDI;
    // lw aborted by reset in MEMRD, followed by an R-type
    add(1'b0, 6'h23, 4'd0, cb);
    add(1'b0, 6'h23, 4'd1, cb);
    add(1'b0, 6'h23, 4'd2, cb);
    add(1'b1, 6'h23, 4'd3, cb);
    add(1'b0, 6'h00, 4'd0, 0);
    add(1'b0, 6'h00, 4'd1, 0);
    add(1'b0, 6'h00, 4'd6, 0);
    add(1'b0, 6'h00, 4'd7, 0);
    add(1'b0, 6'h00, 4'd0, 1);

    bus1.opcode = 6'h23;
    bus2.opcode = 6'h00;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v = vecs[i];
      reset1 = v.rst;
      bus1.opcode = v.opc;
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      exp_ctrl = ctrl_tab[e.exp_state];
      if (e.rst) exp_ctrl = exp_ctrl & ~RST_STROBES;
      chk($sformatf("v%0d state", i), {28'd0, bus1.state}, {28'd0, e.exp_state});
      chk($sformatf("v%0d count", i), bus1.instr_count, e.exp_count);
      chk($sformatf("v%0d ctrl", i), {15'd0, ctrl1}, {15'd0, exp_ctrl});
    end

    // COUNT_WIDTH=4: 16 R-types wrap the counter, then reset beats an increment
    @(negedge clk);
    reset2 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      repeat (4) @(negedge clk);
      if (i == 1 || i == 15 || i == 16) begin
        chk($sformatf("wrap count %0d", i), {28'd0, bus2.instr_count}, (i % 16));
        chk($sformatf("wrap state %0d", i), {28'd0, bus2.state}, 32'd0);
      end
    end
    repeat (4) @(negedge clk);
    chk("w4 count after wrap", {28'd0, bus2.instr_count}, 32'd1);
    repeat (3) @(negedge clk);
    chk("w4 in RTYPE_WB", {28'd0, bus2.state}, 32'd7);
    reset2 = 1'b1;
    #1;
    chk("w4 RegWrite masked", {31'd0, bus2.RegWrite}, 32'd0);
    @(negedge clk);
    chk("w4 reset over incr", {28'd0, bus2.instr_count}, 32'd0);
    chk("w4 state after reset", {28'd0, bus2.state}, 32'd0);
    reset2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_multi.md
Name: control_multi

Overview:
- Moore-FSM control unit for the multicycle MIPS datapath (COD3e §5.5): single shared memory, IR/MDR/A/B/ALUOut registers.
- Sequences each instruction through 3–5 states, driving every datapath mux select and write strobe from the current state.
- Takes the opcode from the instruction register; also exposes its state and a retired-instruction counter for the testbench.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces state to IF
opcode  input  6  IR[31:26]
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if Zero (beq)
PCWriteCondNE  output  1  PC load if !Zero (bne)
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  0=ALUOut, 1=MDR to register file
RegDst  output  1  0=rt, 1=rd write register
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding (debug)
instr_count  output  COUNT_WIDTH  retired legal instructions

Behaviour:
- State encodings: IF=0, ID=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, BNE_EX=9, JUMP_EX=10, ADDI_EX=11, ADDI_WB=12. Codes 13–15 are unreachable; if entered, next state is IF.
- Opcodes: R=0x00, j=0x02, beq=0x04, bne=0x05, addi=0x08, lw=0x23, sw=0x2B.
- Transitions:
  - IF->ID.
  - ID: lw/sw->MEMADR, R->RTYPE_EX, beq->BEQ_EX, bne->BNE_EX, j->JUMP_EX, addi->ADDI_EX; any other opcode->IF (illegal, not counted).
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB.
  - RTYPE_EX->RTYPE_WB.
  - ADDI_EX->ADDI_WB.
  - MEMWB, MEMWR, RTYPE_WB, BEQ_EX, BNE_EX, JUMP_EX, ADDI_WB -> IF.
- Outputs are pure decode of state. Unlisted outputs are 0; unlisted selects are 0 (don't-care).
  - IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1.
  - ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: MemWrite=1, IorD=1.
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - BNE_EX: same as BEQ_EX, but PCWriteCondNE=1 instead of PCWriteCond.
  - JUMP_EX: PCWrite=1, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1.
- Cycle counts per instruction (IF to IF):
  - lw 5; sw 4; R 4; addi 4.
  - beq/bne/j 3; illegal 2.
- Reset:
  - At the clock edge with reset=1: state<=IF, instr_count<=0.
  - While reset=1, these strobes are forced to 0 regardless of state: PCWrite, PCWriteCond, PCWriteCondNE, MemRead, MemWrite, IRWrite, RegWrite.
  - All other outputs follow the state decode.
  - Reset asserted mid-instruction (any state) aborts it: no strobe fires that cycle, the instruction is not counted, and the first cycle after deassertion is IF.
- instr_count:
  - Increments by 1 on the edge leaving any terminal state (MEMWB, MEMWR, RTYPE_WB, BEQ_EX, BNE_EX, JUMP_EX, ADDI_WB) when reset=0.
  - Wraps modulo 2^COUNT_WIDTH.
  - Reset has priority over increment.
- opcode is sampled only in ID and MEMADR. Its value in other states is ignored (IR is stable after IF).

Optional Feature:
ADDI_EN:
- Defined: addi support as specified above.
- Undefined: ADDI_EX/ADDI_WB are not generated; opcode 0x08 in ID is illegal and goes to IF without incrementing instr_count. Encodings 11–12 become unreachable (next state IF).

Test Plan:
- Reset held 2 cycles, then released; opcode=0x23 -> state sequence 0,1,2,3,4,0; MemRead=1 in states 0 and 3; RegWrite=1 only in state 4; instr_count=1.
- sw (0x2B) then R-type (0x00) -> states 0,1,2,5,0,1,6,7,0; MemWrite=1 only in state 5; RegDst=1 in state 7; instr_count=2.
- beq (0x04), bne (0x05), j (0x02) back-to-back -> each takes 3 cycles. PCWriteCond=1 only in state 8; PCWriteCondNE=1 only in state 9; PCWrite=1 with PCSource=10 in state 10; instr_count=3.
- Illegal opcode 0x3F, then addi 0x08:
  - 0x3F -> states 0,1,0, count unchanged.
  - With ADDI_EN: 0x08 -> states 0,1,11,12,0, count +1.
  - Without ADDI_EN: 0x08 -> states 0,1,0, count unchanged.
- Reset asserted in MEMRD of a lw -> MemRead=0 that cycle, state=0 after the edge, instr_count=0, no RegWrite pulse.
- COUNT_WIDTH=4: 16 consecutive R-type instructions -> instr_count wraps 15->0.
